// File: rtl/poly_period_averager.sv
// Polyphonic half-period averager: scans the key vector one key per cycle, sums note
// half-periods, then divides by the pressed-key count. Define POLY_PERIOD_HOLD_EN to hold the last value on silence.
module poly_period_averager #(
   parameter int NUM_KEYS = 12,
   parameter int PERIOD_W = 10,
   localparam int SUM_W = PERIOD_W + $clog2(NUM_KEYS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] keys,
   output logic [PERIOD_W-1:0] half_period_total,
   output logic                period_valid,
   output logic                busy
);

   localparam int CNT_W = $clog2(NUM_KEYS + 1);
   localparam int IDX_W = $clog2(NUM_KEYS + SUM_W + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCUM  = 2'd1;
   localparam logic [1:0] DIVIDE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [NUM_KEYS-1:0] snap_q, snap_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    rem_q, rem_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [PERIOD_W-1:0] out_q, out_d;
   logic                valid_q, valid_d;
   logic                snapBit;
   logic [CNT_W:0]      trial;

   // Base half-periods are one octave (C4..B4); higher octaves halve per step.
   function automatic logic [PERIOD_W-1:0] keyPeriod(input int idx);
      logic [7:0] base;
      case (idx % 12)
         0:       base = 8'd92;
         1:       base = 8'd87;
         2:       base = 8'd82;
         3:       base = 8'd77;
         4:       base = 8'd73;
         5:       base = 8'd69;
         6:       base = 8'd65;
         7:       base = 8'd61;
         8:       base = 8'd58;
         9:       base = 8'd55;
         10:      base = 8'd51;
         default: base = 8'd49;
      endcase
      return PERIOD_W'(base >> (idx / 12));
   endfunction

   // The sum register doubles as the divider's dividend/quotient shift register.
   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      idx_d   = idx_q;
      out_d   = out_q;
      valid_d = 1'b0;
      snapBit = |(snap_q & (NUM_KEYS'(1) << idx_q));
      trial   = {rem_q, sum_q[SUM_W-1]};
      case (state_q)
         IDLE: begin
            if (keys != snap_q) begin
               snap_d  = keys;
               sum_d   = '0;
               cnt_d   = '0;
               rem_d   = '0;
               idx_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (snapBit) begin
               sum_d = sum_q + SUM_W'(keyPeriod(int'(idx_q)));
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (idx_q == IDX_W'(NUM_KEYS - 1)) begin
               idx_d   = '0;
               state_d = (cnt_d == '0) ? DONE : DIVIDE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DIVIDE: begin
            if (trial >= {1'b0, cnt_q}) begin
               rem_d = CNT_W'(trial - {1'b0, cnt_q});
               sum_d = {sum_q[SUM_W-2:0], 1'b1};
            end else begin
               rem_d = CNT_W'(trial);
               sum_d = {sum_q[SUM_W-2:0], 1'b0};
            end
            if (idx_q == IDX_W'(SUM_W - 1)) begin
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: begin
            valid_d = 1'b1;
`ifdef POLY_PERIOD_HOLD_EN
            if (cnt_q != '0) begin
               out_d = sum_q[PERIOD_W-1:0];
            end
`else
            out_d = sum_q[PERIOD_W-1:0];
`endif
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         snap_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         rem_q   <= '0;
         idx_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign half_period_total = out_q;
   assign period_valid      = valid_q;
   assign busy              = (state_q == ACCUM) || (state_q == DIVIDE);

endmodule

// File: tb/tb_poly_period_averager.sv
// Testbench for poly_period_averager: 12-key and 24-key instances checked against
// a plain-arithmetic mean-of-half-periods model.
module tb_poly_period_averager;

`ifdef POLY_PERIOD_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [11:0] keys12;
   logic [23:0] keys24;
   logic [9:0]  out12, out24;
   logic        valid12, valid24;
   logic        busy12, busy24;

   int nChecks = 0;
   int nPass   = 0;
   int base [12] = '{92, 87, 82, 77, 73, 69, 65, 61, 58, 55, 51, 49};
   int prev12  = 0;
   int prev24  = 0;

   typedef struct {
      logic [11:0] keys;
      int          expVal;
   } vec_t;

   vec_t vecs [6];

   poly_period_averager #(.NUM_KEYS(12), .PERIOD_W(10)) dut (
      .clk(clk), .rst(rst), .keys(keys12),
      .half_period_total(out12), .period_valid(valid12), .busy(busy12)
   );

   poly_period_averager #(.NUM_KEYS(24), .PERIOD_W(10)) dut24 (
      .clk(clk), .rst(rst), .keys(keys24),
      .half_period_total(out24), .period_valid(valid24), .busy(busy24)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: mean of the pressed notes' half-periods, rounded down.
   function automatic int refCount(input logic [23:0] k, input int n);
      int c = 0;
      for (int i = 0; i < n; i++) if (k[i]) c++;
      return c;
   endfunction

   function automatic int refAvg(input logic [23:0] k, input int n, input int prev);
      int s = 0;
      int c = 0;
      for (int i = 0; i < n; i++) begin
         if (k[i]) begin
            s += base[i % 12] / (1 << (i / 12));
            c++;
         end
      end
      if (c == 0) return HOLD ? prev : 0;
      return s / c;
   endfunction

   function automatic int refLatency(input logic [23:0] k, input int n);
      int sumW = 10 + $clog2(n + 1);
      return (refCount(k, n) == 0) ? (n + 2) : (n + sumW + 2);
   endfunction

   function automatic int refBusy(input logic [23:0] k, input int n);
      int sumW = 10 + $clog2(n + 1);
      return (refCount(k, n) == 0) ? n : (n + sumW);
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      nChecks++;
      if (actual == expected) nPass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Drives new keys on one instance and measures latency, busy cycles, result and pulse width.
   task automatic applyStimulus(input int which, input logic [23:0] k,
                                output int lat, output int busyCnt,
                                output int val, output int pulseOk);
      @(negedge clk);
      if (which == 12) keys12 = k[11:0];
      else keys24 = k;
      lat = -1;
      busyCnt = 0;
      val = -1;
      pulseOk = 0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if ((which == 12) ? busy12 : busy24) busyCnt++;
         if ((which == 12) ? valid12 : valid24) begin
            lat = c;
            val = (which == 12) ? int'(out12) : int'(out24);
            break;
         end
      end
      @(negedge clk);
      pulseOk = ((which == 12) ? valid12 : valid24) ? 0 : 1;
   endtask

   task automatic runAndCheck(input string name, input int which, input logic [23:0] k,
                              input int expVal);
      int lat, busyCnt, val, pulseOk;
      int n = which;
      applyStimulus(which, k, lat, busyCnt, val, pulseOk);
      checkOutput({name, "_value"}, val, expVal);
      checkOutput({name, "_latency"}, lat, refLatency(k, n));
      checkOutput({name, "_busy"}, busyCnt, refBusy(k, n));
      checkOutput({name, "_pulse"}, pulseOk, 1);
      if (which == 12) prev12 = expVal;
      else prev24 = expVal;
   endtask

   initial begin
      int lat, val, cnt, pulses, busyCnt;
      logic [23:0] k;

      vecs[0] = '{12'h001, 92};
      vecs[1] = '{12'h201, 73};
      vecs[2] = '{12'hFFF, 68};
      vecs[3] = '{12'h800, 49};
      vecs[4] = '{12'h000, HOLD ? 49 : 0};
      vecs[5] = '{12'h00F, 84};

      rst = 1'b0;
      keys12 = '0;
      keys24 = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_out", int'(out12), 0);
      checkOutput("reset_valid", int'(valid12), 0);
      checkOutput("reset_busy", int'(busy12), 0);
      checkOutput("reset_out24", int'(out24), 0);
      rst = 1'b1;
      pulses = 0;
      busyCnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (valid12) pulses++;
         if (busy12) busyCnt++;
      end
      checkOutput("idle_pulses", pulses, 0);
      checkOutput("idle_busy", busyCnt, 0);
      checkOutput("idle_out", int'(out12), 0);

      for (int i = 0; i < 6; i++) begin
         runAndCheck($sformatf("vec%0d", i), 12, {12'h000, vecs[i].keys}, vecs[i].expVal);
      end

      runAndCheck("single_c4", 12, 24'h001, 92);
      runAndCheck("release_all", 12, 24'h000, HOLD ? 92 : 0);

      // Key change in the middle of the divide phase must not corrupt the running result.
      @(negedge clk);
      keys12 = 12'h001;
      lat = -1;
      val = -1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (c == 20) keys12 = 12'h002;
         if (valid12) begin
            lat = c;
            val = int'(out12);
            break;
         end
      end
      checkOutput("middiv_first_latency", lat, 28);
      checkOutput("middiv_first_value", val, 92);
      lat = -1;
      val = -1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (valid12) begin
            lat = c;
            val = int'(out12);
            break;
         end
      end
      checkOutput("middiv_second_gap", lat, 28);
      checkOutput("middiv_second_value", val, 87);
      prev12 = 87;

      @(negedge clk);
      keys12 = 12'h002;
      pulses = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (valid12) pulses++;
      end
      checkOutput("same_keys_pulses", pulses, 0);
      checkOutput("same_keys_hold", int'(out12), 87);

      runAndCheck("k24_bit21", 24, 24'h200000, 27);
      runAndCheck("k24_bits0_12", 24, 24'h001001, 69);

      for (int i = 0; i < 16; i++) begin
         k = {12'h000, 12'($urandom)};
         if ($urandom_range(0, 7) == 0) k = '0;
         if (k[11:0] == keys12) k[0] = ~k[0];
         runAndCheck($sformatf("rand12_%0d", i), 12, k, refAvg(k, 12, prev12));
      end
      for (int i = 0; i < 8; i++) begin
         k = 24'($urandom);
         if ($urandom_range(0, 7) == 0) k = '0;
         if (k == keys24) k[5] = ~k[5];
         runAndCheck($sformatf("rand24_%0d", i), 24, k, refAvg(k, 24, prev24));
      end

      k = (keys12 == 12'h003) ? 24'h005 : 24'h003;
      runAndCheck("pre_reset", 12, k, refAvg(k, 12, prev12));

      // Reset in the middle of the accumulate phase clears outputs at once.
      @(negedge clk);
      keys12 = 12'h0F0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("midrst_out", int'(out12), 0);
      checkOutput("midrst_busy", int'(busy12), 0);
      checkOutput("midrst_valid", int'(valid12), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      lat = -1;
      val = -1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (busy12) cnt++;
         if (valid12) begin
            lat = c;
            val = int'(out12);
            break;
         end
      end
      checkOutput("postrst_latency", lat, 28);
      checkOutput("postrst_value", val, 67);
      checkOutput("postrst_busy", cnt, 26);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
